// File: rtl/spi_master_sequencer.sv
// Sequences one read or write command into byte-wise start/stop handshakes with the
// serializer_deserializer SPI engine, collecting read bytes and guarding each wait.
//
// state     | meaning
// IDLE      | waiting for a command; chip select released
// LOAD      | waiting for the next write byte from the TX stream
// ISSUE     | start plus read/write raised; waiting for the engine irq
// RELEASE   | start dropped; waiting for the engine irq to clear
// RXPUSH    | presenting a read byte until the consumer takes it
// STOP      | stop raised; waiting for transfer complete
// STOP_REL  | stop dropped; waiting for transfer complete to clear
module spi_master_sequencer #(
    parameter int LEN_W     = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 Bus_CLK_i,
    input  logic                 RST_SYNC_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_rd_i,
    input  logic [LEN_W-1:0]     cmd_len_i,
    input  logic [7:0]           cmd_cs_i,
    input  logic                 tx_valid_i,
    input  logic [7:0]           tx_data_i,
    output logic                 tx_ready_o,
    output logic                 rx_valid_o,
    output logic [7:0]           rx_data_o,
    input  logic                 rx_ready_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 start_o,
    output logic                 stop_o,
    output logic                 read_o,
    output logic                 write_o,
    output logic [7:0]           spi_wdata_o,
    output logic [7:0]           spi_cs_o,
    input  logic                 irq_write_i,
    input  logic                 irq_read_i,
    input  logic                 xfer_cmplt_i,
    input  logic [7:0]           spi_rdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_ISSUE    = 3'd2,
        S_RELEASE  = 3'd3,
        S_RXPUSH   = 3'd4,
        S_STOP     = 3'd5,
        S_STOP_REL = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic                 rd_q, rd_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic [TIMEOUT_W:0]   wdog_next;
    logic                 irq_sel;
    logic                 wd_fire;
    logic                 abort;

    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       read_q, read_d;
    logic       write_q, write_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] cs_q, cs_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rx_data_q, rx_data_d;

    assign irq_sel   = rd_q ? irq_read_i : irq_write_i;
    assign wdog_next = {1'b0, wdog_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
    // Fires on the timeout_i-th cycle spent in a guarded state, only while still waiting.
    assign wd_fire   = (timeout_i != '0) && (wdog_next >= {1'b0, timeout_i});

    always_ff @(posedge Bus_CLK_i) begin
        if (RST_SYNC_i) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    rd_d    = cmd_rd_i;
                    cnt_d   = cmd_len_i;
                    state_d = cmd_rd_i ? S_ISSUE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (tx_valid_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (irq_sel)      state_d = S_RELEASE;
                else if (wd_fire) abort   = 1'b1;
            end
            S_RELEASE: begin
                if (!irq_sel) begin
                    if (rd_q) begin
                        state_d = S_RXPUSH;
                    end else if (cnt_q != '0) begin
                        state_d = S_LOAD;
                        cnt_d   = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = S_STOP;
                    end
                end else if (wd_fire) begin
                    abort = 1'b1;
                end
            end
            S_RXPUSH: begin
                if (rx_ready_i) begin
                    if (cnt_q != '0) begin
                        state_d = S_ISSUE;
                        cnt_d   = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (xfer_cmplt_i) state_d = S_STOP_REL;
                else if (wd_fire) abort   = 1'b1;
            end
            S_STOP_REL: begin
                if (!xfer_cmplt_i) state_d = S_IDLE;
                else if (wd_fire)  abort   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;

        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (state_q inside {S_ISSUE, S_RELEASE, S_STOP, S_STOP_REL}) begin
            wdog_d = wdog_next[TIMEOUT_W-1:0];
        end else begin
            wdog_d = wdog_q;
        end
    end

    // Registered outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        start_d    = (state_d == S_ISSUE);
        read_d     = start_d & rd_d;
        write_d    = start_d & ~rd_d;
        stop_d     = (state_d == S_STOP);
        rx_valid_d = (state_d == S_RXPUSH);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_q == S_STOP_REL) && (state_d == S_IDLE) && !abort;

        err_d = err_q;
        if (abort)                                     err_d = 1'b1;
        else if ((state_q == S_IDLE) && cmd_valid_i)   err_d = 1'b0;

        cs_d = cs_q;
        if (state_d == S_IDLE)      cs_d = '0;
        else if (state_q == S_IDLE) cs_d = cmd_cs_i;

        wdata_d = wdata_q;
        if ((state_q == S_LOAD) && tx_valid_i) wdata_d = tx_data_i;

        rx_data_d = rx_data_q;
        if ((state_q == S_ISSUE) && rd_q && irq_read_i) rx_data_d = spi_rdata_i;
    end

    always_ff @(posedge Bus_CLK_i) begin
        if (RST_SYNC_i) begin
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cs_q       <= '0;
            wdata_q    <= '0;
            rx_data_q  <= '0;
        end else begin
            start_q    <= start_d;
            stop_q     <= stop_d;
            read_q     <= read_d;
            write_q    <= write_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cs_q       <= cs_d;
            wdata_q    <= wdata_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign tx_ready_o  = (state_q == S_LOAD) & tx_valid_i;
    assign start_o     = start_q;
    assign stop_o      = stop_q;
    assign read_o      = read_q;
    assign write_o     = write_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_data_o   = rx_data_q;
    assign spi_wdata_o = wdata_q;
    assign spi_cs_o    = cs_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
